// File: rtl/split_2_pkg.sv
// Shared types and constants for the split_2 constraint-solution generator.
// The candidate word is {var_20, var_8}; the LFSR helper is used by RTL and bench alike.
package split_2_pkg;

  localparam int CAND_W = 12;
  localparam int V20_W  = 8;
  localparam int V8_W   = 4;
  localparam int CNT_W  = 13;

  localparam logic [V20_W-1:0]  EXCL_V20  = 8'h11;
  // Fibonacci taps for x^12+x^6+x^4+x+1: bits 11, 5, 3 and 0 of the state.
  localparam logic [CAND_W-1:0] LFSR_TAPS = 12'h829;
  localparam logic [CAND_W-1:0] CAND_LAST = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [CAND_W-1:0] lfsr_next(input logic [CAND_W-1:0] s);
    return {s[CAND_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/split_2_check.sv
// Combinational constraint predicate: sat is high when (var_20, var_8) is a legal solution.
// The only rejected points are var_20 == EXCL_V20 and the single point (8'hFF, 4'h0).
module split_2_check
  import split_2_pkg::*;
(
  input  logic [V20_W-1:0] var_20,
  input  logic [V8_W-1:0]  var_8,
  output logic             sat
);

  logic [V20_W-1:0] mix;

  always_comb begin
    mix = {4'h0, var_8} | ~var_20;
    sat = (var_20 != EXCL_V20) && (mix != '0);
  end

endmodule

// File: rtl/split_2_gen.sv
// Enumerates satisfying (var_20, var_8) assignments in ordered or LFSR order, one candidate
// per SCAN cycle, and hands each solution to the consumer through a valid/ready output.
module split_2_gen
  import split_2_pkg::*;
#(
  parameter logic [CAND_W-1:0] LFSR_SEED   = 12'hACE,
  parameter logic [CAND_W-1:0] MAX_DEFAULT = 12'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CAND_W-1:0] max_cnt,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [V20_W-1:0] var_20,
  output logic [V8_W-1:0]  var_8,
  output logic [CNT_W-1:0] sol_cnt,
  output logic             busy,
  output logic             done,
  output state_t           fsm_state
);

  // Handshake: a solution transfers on a rising edge where out_valid and out_ready are both
  // high; while out_valid is high and out_ready low, var_20/var_8 hold their value.

  state_t            state;
  logic [CAND_W-1:0] cand;
  logic [CAND_W-1:0] lfsr;
  logic              mode_r;
  logic [CAND_W-1:0] lim_r;

  logic [CAND_W-1:0] cur;
  logic              last;
  logic              sat;
  logic              accept;
  logic              lim_hit;

  assign fsm_state = state;

  // Ordered mode walks cand; random mode walks the LFSR, which never reaches zero.
  assign cur     = mode_r ? lfsr : cand;
  assign last    = mode_r ? (lfsr_next(lfsr) == LFSR_SEED) : (cand == CAND_LAST);
  assign accept  = (state == S_HOLD) && out_ready;
  assign lim_hit = (lim_r != '0) && ((sol_cnt + 13'd1) == {1'b0, lim_r});

  split_2_check u_check (
    .var_20 (cur[CAND_W-1:V8_W]),
    .var_8  (cur[V8_W-1:0]),
    .sat    (sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      var_20    <= '0;
      var_8     <= '0;
      sol_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cand      <= '0;
      lfsr      <= LFSR_SEED;
      mode_r    <= 1'b0;
      lim_r     <= '0;
    end else if (abort) begin
      // Abort wins over everything, but a transfer on the same edge still counts.
      if (accept) sol_cnt <= sol_cnt + 13'd1;
      state     <= S_DONE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_SCAN;
            cand    <= '0;
            lfsr    <= LFSR_SEED;
            sol_cnt <= '0;
            mode_r  <= mode;
            lim_r   <= (max_cnt != '0) ? max_cnt : MAX_DEFAULT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (sat) begin
            var_20    <= cur[CAND_W-1:V8_W];
            var_8     <= cur[V8_W-1:0];
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            if (mode_r) lfsr <= lfsr_next(lfsr);
            else        cand <= cand + 12'd1;
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            sol_cnt   <= sol_cnt + 13'd1;
            out_valid <= 1'b0;
            if (mode_r) lfsr <= lfsr_next(lfsr);
            else        cand <= cand + 12'd1;
            if (lim_hit || last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  a_valid_only_in_hold: assert property (@(posedge clk) out_valid |-> (state == S_HOLD));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !abort) |=> (out_valid && $stable({var_20, var_8})));

  a_busy_matches_state: assert property (@(posedge clk)
    busy == ((state == S_SCAN) || (state == S_HOLD)));

endmodule

// File: tb/tb_split_2_gen.sv
// Bench for split_2_gen: predicate table on split_2_check, a table of generation runs
// checked against an ordered-solution queue, and directed abort/reset/start sequences.
module tb_split_2_gen;
  import split_2_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [CAND_W-1:0] max_cnt = '0;
  logic              abort = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [V20_W-1:0]  var_20;
  logic [V8_W-1:0]   var_8;
  logic [CNT_W-1:0]  sol_cnt;
  logic              busy;
  logic              done;
  state_t            fsm_state;

  logic [V20_W-1:0]  t_v20 = '0;
  logic [V8_W-1:0]   t_v8 = '0;
  logic              t_sat;

  int n_vec = 0;
  int n_err = 0;
  logic [CAND_W-1:0] exp_q[$];
  bit seen [4096];

  always #5 clk = ~clk;

  split_2_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .max_cnt(max_cnt), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .var_20(var_20), .var_8(var_8),
    .sol_cnt(sol_cnt), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  split_2_check ref_chk (.var_20(t_v20), .var_8(t_v8), .sat(t_sat));

  typedef struct {
    logic [7:0] v20;
    logic [3:0] v8;
    logic       sat;
  } pred_vec_t;

  typedef struct {
    logic        m;
    logic [11:0] mc;
    int          exp_n;
    int          rdy_style;
    bit          poke;
  } run_vec_t;

  function automatic bit model_sat(input logic [11:0] c);
    return (c[11:4] != 8'h11) && (c != 12'hFF0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_gen(input logic m, input logic [11:0] mc, input int exp_n,
                         input int rdy_style, input bit poke);
    int n_acc, cyc, vcnt, lim;
    logic [11:0] got, held;
    logic rdy, was_held;
    exp_q.delete();
    foreach (seen[i]) seen[i] = 1'b0;
    lim = (mc == 0) ? 4096 : int'(mc);
    if (!m) begin
      for (int c = 0; c < 4096; c++)
        if (model_sat(12'(c)) && exp_q.size() < lim) exp_q.push_back(12'(c));
    end
    mode = m; max_cnt = mc; start = 1'b1;
    tick();
    start = 1'b0;
    n_acc = 0; cyc = 0; vcnt = 0; was_held = 1'b0; held = '0;
    while (!done && cyc < 20000) begin
      chk("sol_cnt_track", 32'(sol_cnt), 32'(n_acc));
      case (rdy_style)
        0:       rdy = 1'b1;
        1:       rdy = (vcnt % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid) begin
        got = {var_20, var_8};
        vcnt++;
        if (was_held) chk("hold_stable", 32'(got), 32'(held));
        if (rdy) begin
          n_acc++;
          was_held = 1'b0;
          if (!m) begin
            if (exp_q.size() == 0) chk("extra_output", 32'(got), 32'hFFFF_FFFF);
            else chk("ordered_out", 32'(got), 32'(exp_q.pop_front()));
          end else begin
            chk("rand_sat", 32'(model_sat(got)), 32'd1);
            chk("rand_nonzero", 32'(got != 12'h000), 32'd1);
            chk("rand_dup", 32'(seen[got]), 32'd0);
            seen[got] = 1'b1;
          end
        end else begin
          was_held = 1'b1;
          held = got;
        end
      end
      start = poke && (cyc % 7 == 3);
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 20000) chk("run_timeout", 32'(cyc), 32'd0);
    chk("run_done", 32'(done), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_valid_low", 32'(out_valid), 32'd0);
    chk("run_sol_cnt", 32'(sol_cnt), 32'(exp_n));
    chk("run_accepts", 32'(n_acc), 32'(exp_n));
    if (!m) chk("run_queue_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  pred_vec_t pv[10];
  run_vec_t  rv[6];

  initial begin
    int cyc;
    pv[0] = '{8'h00, 4'h0, 1'b1};
    pv[1] = '{8'h11, 4'h0, 1'b0};
    pv[2] = '{8'h11, 4'hF, 1'b0};
    pv[3] = '{8'hFF, 4'h0, 1'b0};
    pv[4] = '{8'hFF, 4'h1, 1'b1};
    pv[5] = '{8'hFF, 4'hF, 1'b1};
    pv[6] = '{8'h10, 4'hF, 1'b1};
    pv[7] = '{8'h12, 4'h0, 1'b1};
    pv[8] = '{8'hFE, 4'h0, 1'b1};
    pv[9] = '{8'h01, 4'h1, 1'b1};

    rv[0] = '{1'b0, 12'd0,     4079, 0, 1'b0};
    rv[1] = '{1'b0, 12'd3,     3,    1, 1'b0};
    rv[2] = '{1'b1, 12'd0,     4078, 0, 1'b0};
    rv[3] = '{1'b0, 12'h110,   272,  2, 1'b0};
    rv[4] = '{1'b0, 12'h111,   273,  0, 1'b1};
    rv[5] = '{1'b1, 12'd5,     5,    2, 1'b0};

    for (int i = 0; i < 10; i++) begin
      t_v20 = pv[i].v20;
      t_v8  = pv[i].v8;
      #1;
      chk("pred_table", 32'(t_sat), 32'(pv[i].sat));
    end

    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_vars", 32'({var_20, var_8}), 32'd0);
    chk("rst_sol_cnt", 32'(sol_cnt), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);

    for (int i = 0; i < 6; i++)
      run_gen(rv[i].m, rv[i].mc, rv[i].exp_n, rv[i].rdy_style, rv[i].poke);

    // Abort while holding the first solution with the consumer stalled.
    mode = 1'b0; max_cnt = '0; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("abort_wait_valid");
    chk("abort_first_out", 32'({var_20, var_8}), 32'h000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_hold", 32'({out_valid, var_20, var_8}), 32'h1000);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid_low", 32'(out_valid), 32'd0);
    chk("abort_sol_cnt", 32'(sol_cnt), 32'd0);
    chk("abort_done", 32'({busy, done}), 32'd1);

    // Abort on the same edge as an acceptance: the transfer is still counted.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("abort_acc_wait_valid");
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_acc_sol_cnt", 32'(sol_cnt), 32'd1);
    chk("abort_acc_state", 32'(fsm_state), 32'(S_DONE));
    chk("abort_acc_valid", 32'(out_valid), 32'd0);

    // Reset while holding candidate 0x120.
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && {var_20, var_8} == 12'h120) && cyc < 2000) begin
      out_ready = 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("rst_mid_reached", 32'({var_20, var_8}), 32'h120);
    tick();
    chk("rst_mid_state", 32'(fsm_state), 32'(S_HOLD));
    chk("rst_mid_sol_cnt", 32'(sol_cnt), 32'd272);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_clear", 32'({out_valid, busy, done, sol_cnt, var_20, var_8}), 32'd0);
    chk("rst_mid_idle", 32'(fsm_state), 32'(S_IDLE));
    run_gen(1'b0, 12'd2, 2, 0, 1'b0);

    // start together with abort from IDLE lands in DONE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_state", 32'(fsm_state), 32'(S_DONE));
    chk("start_abort_flags", 32'({busy, done, out_valid}), 32'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/split_2_gen.md
SPLIT_2_GEN -- requirements
Module: split_2_gen

Interface
REQ-001 Parameter LFSR_SEED, default 12'hACE, nonzero initial state of the random-mode LFSR.
REQ-002 Parameter MAX_DEFAULT, default 12'd0, used as the emission limit when max_cnt is 0; a value of 0 means unlimited.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a generation run; ignored unless in IDLE or DONE.
REQ-006 mode  input  1  sampled on start: 0 = ordered enumeration, 1 = LFSR pseudo-random order.
REQ-007 max_cnt  input  12  sampled on start: number of solutions to emit; 0 selects MAX_DEFAULT.
REQ-008 abort  input  1  terminates a run and forces DONE on the next edge.
REQ-009 out_valid  output  1  a satisfying assignment is presented.
REQ-010 out_ready  input  1  consumer accepts when high together with out_valid.
REQ-011 var_20  output  8  generated value of constraint variable var_20.
REQ-012 var_8  output  4  generated value of constraint variable var_8.
REQ-013 sol_cnt  output  13  number of solutions accepted in the current or last run.
REQ-014 busy  output  1  high in SCAN or HOLD.
REQ-015 done  output  1  high in DONE until the next start or reset.

Function
REQ-016 The candidate space shall be 12 bits, cand[11:4] = var_20 and cand[3:0] = var_8.
REQ-017 A candidate shall be a solution iff var_20 != 8'h11 AND ({4'h0,var_8} | ~var_20) != 0; the constant-true term is always satisfied and shall not gate the result.
REQ-018 The FSM shall have four states: IDLE, SCAN, HOLD and DONE.
REQ-019 IDLE/DONE -> SCAN on start; cand and sol_cnt clear, and the run parameters latch.
REQ-020 In SCAN, exactly one candidate shall be tested per cycle.
REQ-021 In SCAN, a solution shall register into var_20/var_8 and move the FSM to HOLD, giving out_valid one cycle after the test.
REQ-022 In SCAN, a non-solution shall advance the candidate with no output.
REQ-023 In HOLD, out_valid, var_20 and var_8 shall stay stable until out_ready is high.
REQ-024 On acceptance, sol_cnt shall increment and the candidate shall advance.
REQ-025 After acceptance, the FSM shall go to DONE if the limit is reached or the space is exhausted, otherwise back to SCAN.
REQ-026 Ordered mode shall run cand from 0x000 to 0xFFF incrementing; the space is exhausted after 0xFFF is tested, with no wrap.
REQ-027 Random mode shall use a 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1, seeded with LFSR_SEED.
REQ-028 Random mode shall visit all 4095 nonzero states; the space is exhausted when the next state equals the seed, and candidate 0x000 is never produced.
REQ-029 If the space is exhausted in SCAN on a non-solution, the FSM shall go directly to DONE.
REQ-030 abort shall take priority over every transition except rst, including simultaneous acceptance; a simultaneous acceptance still increments sol_cnt.
REQ-031 After abort, out_valid shall be low, sol_cnt shall be retained and done shall be high.
REQ-032 start received in SCAN or HOLD shall be ignored.
REQ-033 start and abort together in IDLE shall result in DONE.
REQ-034 out_valid shall never be asserted outside HOLD.

Reset
REQ-035 rst shall force IDLE, out_valid=0, var_20=0, var_8=0, sol_cnt=0, busy=0, done=0, cand=0 and LFSR=LFSR_SEED.
REQ-036 rst asserted mid-run (SCAN or HOLD) shall discard the pending output with no acceptance counted.

Structure
REQ-037 Shared package split_2_pkg shall hold the state enum, CAND_W=12, V20_W=8, V8_W=4, EXCL_V20=8'h11, LFSR_TAPS and the helper constants.
REQ-038 The predicate shall be a separate combinational sub-module, split_2_check (inputs var_20 and var_8, output sat), instantiated once and reusable by the bench as a reference checker.

Verification
REQ-039 Ordered mode, max_cnt=0, out_ready=1: expect 4079 outputs; first (0x00,0x0); (0x10,0xF) followed by (0x12,0x0); (0xFF,0x0) absent; last (0xFF,0xF); sol_cnt=4079; done=1.
REQ-040 Ordered mode, max_cnt=3, out_ready toggling 1-0-1: expect outputs (0x00,0x0), (0x00,0x1), (0x00,0x2), stable while ready is low; sol_cnt=3; then DONE.
REQ-041 Random mode, max_cnt=0, out_ready=1: every output satisfies split_2_check; no duplicates; sol_cnt=4078; done=1.
REQ-042 Ordered mode, out_ready=0 held at (0x00,0x0), abort pulsed: out_valid drops the next cycle; sol_cnt=0; done=1.
REQ-043 rst asserted in HOLD at candidate 0x120, then start in ordered mode: first output (0x00,0x0); sol_cnt restarts at 0.
REQ-044 start pulsed during SCAN: no effect; the run continues uninterrupted and sol_cnt is monotonic.
